ps2_rx_decoder: RTL and testbench



---
 rtl/ps2_rx_decoder_pkg.sv | 30 +++
 rtl/ps2_rx_decoder_if.sv | 16 +
 rtl/ps2_rx_decoder_fifo.sv | 59 +++++
 rtl/ps2_rx_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_rx_decoder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_decoder_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_e  - framing FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_EXT/BRK  - extended (E0) and break (F0) prefix bytes
//   ps2_event_t  - packed key event {ext, brk, code[7:0]}, 10 bits
//   odd_parity_ok- true when data byte plus parity bit has odd weight
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int PS2_EVENT_W = 10;

    function automatic logic odd_parity_ok(input logic [7:0] data_i, input logic par_i);
        return ^{data_i, par_i};
    endfunction

endpackage

// File: rtl/ps2_rx_decoder_if.sv
// ps2_rx_decoder_if: ready/valid key-event stream.
//   ev_valid - head event present        (master -> slave)
//   ev_ready - consumer takes head       (slave -> master)
//   ev_code  - scan code of head event   (master -> slave)
//   ev_ext   - head event was E0-prefixed
//   ev_break - head event is a release
interface ps2_rx_decoder_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/ps2_rx_decoder_fifo.sv
// ps2_event_fifo: generic ready/valid FIFO with a dropped-push pulse.
//   clk, rst_n          - system clock, async active-low reset
//   push_valid_i/data_i - write request and payload
//   pop_ready_i         - consumer accepts head
//   pop_valid_o/data_o  - head present / head payload
//   overflow_o          - one-cycle pulse when a push was dropped (full, no pop)
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_ready_i,
    output logic         pop_valid_o,
    output logic [W-1:0] pop_data_o,
    output logic         overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         ovf_q, ovf_d;
    logic         empty_s, full_s, pop_s, wr_en_s;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Pointer advance and overflow detection; a pop frees the slot for a same-cycle push.
    always_comb begin
        pop_s    = !empty_s && pop_ready_i;
        wr_en_s  = push_valid_i && (!full_s || pop_s);
        ovf_d    = push_valid_i && full_s && !pop_s;
        wr_ptr_d = wr_en_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s   ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
    end

    // Storage, pointers and overflow pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            if (wr_en_s) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign pop_valid_o = !empty_s;
    assign pop_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o  = ovf_q;
endmodule

// File: rtl/ps2_rx_decoder.sv
// ps2_rx_decoder: system-clock PS/2 keyboard receiver.
//   clk, rst_n         - system clock, async active-low reset
//   ps2_clk, ps2_data  - raw asynchronous PS/2 lines
//   ev (master)        - ready/valid stream of {ext, break, code} key events
//   frame_err          - one-cycle pulse on parity, stop or timeout error
//   overflow           - one-cycle pulse when an event is dropped (FIFO full)
// Optional build macro REPEAT_FILTER_EN suppresses typematic repeats of the
// last pushed make; without it every make is pushed.
module ps2_rx_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    ps2_rx_decoder_if.master    ev,
    output logic                frame_err,
    output logic                overflow
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, data_s, fall_s, tmo_hit_s;

    ps2_state_e state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_vld_q, byte_vld_d;
    logic       frame_err_q, frame_err_d;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic       is_key_s, keep_s, push_s;
    ps2_event_t push_ev_s, head_ev_s;
    logic       head_vld_s, ovf_s;

    // Synchronisers idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s     = clk_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign fall_s    = clk_prev_q && !clk_s;
    assign tmo_hit_s = (state_q != IDLE) && !fall_s && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: one transition per ps2_clk fall, timeout returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall_s && !data_s) state_d = DATA; else state_d = IDLE;
            DATA:    if (tmo_hit_s) state_d = IDLE;
                     else if (fall_s && (bitcnt_q == 3'd7)) state_d = PARITY;
                     else state_d = DATA;
            PARITY:  if (tmo_hit_s) state_d = IDLE; else if (fall_s) state_d = STOP; else state_d = PARITY;
            STOP:    if (tmo_hit_s || fall_s) state_d = IDLE; else state_d = STOP;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: bit capture, frame check and timeout counter.
    always_comb begin
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byte_d      = byte_q;
        byte_vld_d  = 1'b0;
        frame_err_d = tmo_hit_s;
        tmo_d       = ((state_q == IDLE) || fall_s) ? TW'(0) : (tmo_q + TW'(1));
        case (state_q)
            IDLE:   if (fall_s && !data_s) bitcnt_d = 3'd0; else bitcnt_d = bitcnt_q;
            DATA:   if (fall_s) begin
                        shift_d  = {data_s, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end else begin
                        shift_d  = shift_q;
                    end
            PARITY: if (fall_s) parity_d = data_s; else parity_d = parity_q;
            STOP:   if (fall_s && data_s && odd_parity_ok(shift_q, parity_q)) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else if (fall_s) begin
                        frame_err_d = 1'b1;
                    end else begin
                        byte_d = byte_q;
                    end
            default: bitcnt_d = 3'd0;
        endcase
    end

    // Framing datapath and completed-byte stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            byte_q      <= 8'd0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
        end
    end

    assign is_key_s = byte_vld_q && (byte_q != PS2_EXT) && (byte_q != PS2_BRK);

    // Prefix folding: E0/F0 arm flags, a key byte consumes them, an error drops them.
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        if (frame_err_q || is_key_s) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q && (byte_q == PS2_EXT)) begin
            ext_d = 1'b1;
        end else if (byte_vld_q) begin
            brk_d = 1'b1;
        end else begin
            ext_d = ext_q;
        end
    end

`ifdef REPEAT_FILTER_EN
    logic       rep_vld_q, rep_vld_d;
    logic [8:0] rep_key_q, rep_key_d;
    logic       rep_match_s;

    assign rep_match_s = rep_vld_q && (rep_key_q == {ext_q, byte_q});

    // Repeat tracker: drop a make equal to the last pushed make; its break clears it.
    always_comb begin
        rep_vld_d = rep_vld_q;
        rep_key_d = rep_key_q;
        keep_s    = 1'b1;
        if (is_key_s && brk_q) begin
            if (rep_match_s) rep_vld_d = 1'b0; else rep_vld_d = rep_vld_q;
        end else if (is_key_s && rep_match_s) begin
            keep_s = 1'b0;
        end else if (is_key_s) begin
            rep_vld_d = 1'b1;
            rep_key_d = {ext_q, byte_q};
        end else begin
            keep_s = 1'b1;
        end
    end

    // Repeat tracker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_vld_q <= 1'b0;
            rep_key_q <= 9'd0;
        end else begin
            rep_vld_q <= rep_vld_d;
            rep_key_q <= rep_key_d;
        end
    end
`else
    assign keep_s = 1'b1;
`endif

    assign push_s    = is_key_s && keep_s;
    assign push_ev_s = '{ext: ext_q, brk: brk_q, code: byte_q};

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PS2_EVENT_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (push_s),
        .push_data_i  (push_ev_s),
        .pop_ready_i  (ev.ev_ready),
        .pop_valid_o  (head_vld_s),
        .pop_data_o   (head_ev_s),
        .overflow_o   (ovf_s)
    );

    assign ev.ev_valid = head_vld_s;
    assign ev.ev_code  = head_ev_s.code;
    assign ev.ev_ext   = head_ev_s.ext;
    assign ev.ev_break = head_ev_s.brk;
    assign frame_err   = frame_err_q;
    assign overflow    = ovf_s;
endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed self-checking bench for ps2_rx_decoder (small timeout for speed).
module tb_ps2_rx_decoder;
    localparam int H   = 8;    // clk cycles per PS/2 clock half-period
    localparam int TMO = 200;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic frame_err, overflow;

    ps2_rx_decoder_if ev_if();

    ps2_rx_decoder #(
        .SYNC_STAGES    (2),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev        (ev_if),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int err_cnt  = 0;
    int ovf_cnt  = 0;
    int base_err, base_ovf;
    logic [9:0] evq[$];

    // Collect accepted events and count pulse cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err) err_cnt <= err_cnt + 1;
        if (overflow)  ovf_cnt <= ovf_cnt + 1;
        if (rst_n && ev_if.ev_valid && ev_if.ev_ready)
            evq.push_back({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        got = 10'h3ff;
        if (evq.size() != 0) got = evq.pop_front();
        check(tag, {22'd0, got}, {22'd0, exp});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: plain bit; 1: check ev_valid latency after this fall; 2: pulse ev_ready in the push cycle
    task automatic send_bit(input logic b, input int mode);
        ps2_data = b;
        wait_cyc(H);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("lat_before", 32'(ev_if.ev_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("lat_at2", 32'(ev_if.ev_valid), 32'd1);
            wait_cyc(H - 4);
        end else if (mode == 2) begin
            repeat (3) @(posedge clk);
            #1 ev_if.ev_ready = 1'b1;
            @(posedge clk);
            #1 ev_if.ev_ready = 1'b0;
            wait_cyc(H - 4);
        end else begin
            wait_cyc(H);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit, input int mode);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 0);
        send_bit((~^b) ^ par_flip, 0);
        send_bit(stop_bit, mode);
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ev_if.ev_ready = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Plain make with latency check
        base_err = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        check("t1_n", evq.size(), 32'd1);
        chk_ev("t1_ev", {2'b00, 8'h1C});
        check("t1_err", err_cnt - base_err, 32'd0);

        // Break and extended break
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check("t2a_n", evq.size(), 32'd1);
        chk_ev("t2a_ev", {2'b01, 8'h1C});
        send_frame(8'hE0, 1'b0, 1'b1, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h75, 1'b0, 1'b1, 0);
        check("t2b_n", evq.size(), 32'd1);
        chk_ev("t2b_ev", {2'b11, 8'h75});

        // Parity error (also drops a pending F0), then stop error
        base_err = err_cnt;
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        check("t3_par_err", err_cnt - base_err, 32'd1);
        check("t3_par_n", evq.size(), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        chk_ev("t3_par_rec", {2'b00, 8'h1C});
        base_err = err_cnt;
        send_frame(8'h1B, 1'b0, 1'b0, 0);
        check("t3_stop_err", err_cnt - base_err, 32'd1);
        check("t3_stop_n", evq.size(), 32'd0);
        send_frame(8'h1B, 1'b0, 1'b1, 0);
        chk_ev("t3_stop_rec", {2'b00, 8'h1B});

        // Timeout mid-frame
        base_err = err_cnt;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        ps2_data = 1'b1;
        wait_cyc(TMO + 50);
        check("t4_tmo_err", err_cnt - base_err, 32'd1);
        send_frame(8'h23, 1'b0, 1'b1, 0);
        chk_ev("t4_rec", {2'b00, 8'h23});
        check("t4_err_after", err_cnt - base_err, 32'd1);

        // Overflow, then full with simultaneous push/pop
        ev_if.ev_ready = 1'b0;
        base_ovf = ovf_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'h1B, 1'b0, 1'b1, 0);
        send_frame(8'h23, 1'b0, 1'b1, 0);
        send_frame(8'h2B, 1'b0, 1'b1, 0);
        check("t5_ovf0", ovf_cnt - base_ovf, 32'd0);
        send_frame(8'h34, 1'b0, 1'b1, 0);
        check("t5_ovf1", ovf_cnt - base_ovf, 32'd1);
        check("t5_held_n", evq.size(), 32'd0);
        @(negedge clk);
        check("t5_head_vld", 32'(ev_if.ev_valid), 32'd1);
        check("t5_head_code", 32'(ev_if.ev_code), 32'h1C);
        send_frame(8'h33, 1'b0, 1'b1, 2);
        check("t5_pp_ovf", ovf_cnt - base_ovf, 32'd1);
        check("t5_pp_n", evq.size(), 32'd1);
        chk_ev("t5_d0", {2'b00, 8'h1C});
        ev_if.ev_ready = 1'b1;
        wait_cyc(10);
        check("t5_drain_n", evq.size(), 32'd4);
        chk_ev("t5_d1", {2'b00, 8'h1B});
        chk_ev("t5_d2", {2'b00, 8'h23});
        chk_ev("t5_d3", {2'b00, 8'h2B});
        chk_ev("t5_d4", {2'b00, 8'h33});
        @(negedge clk);
        check("t5_empty", 32'(ev_if.ev_valid), 32'd0);

        // Typematic repeats
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
`ifdef REPEAT_FILTER_EN
        check("t6_n", evq.size(), 32'd3);
        chk_ev("t6_e0", {2'b00, 8'h1C});
        chk_ev("t6_e1", {2'b01, 8'h1C});
        chk_ev("t6_e2", {2'b00, 8'h1C});
`else
        check("t6_n", evq.size(), 32'd5);
        chk_ev("t6_e0", {2'b00, 8'h1C});
        chk_ev("t6_e1", {2'b00, 8'h1C});
        chk_ev("t6_e2", {2'b00, 8'h1C});
        chk_ev("t6_e3", {2'b01, 8'h1C});
        chk_ev("t6_e4", {2'b00, 8'h1C});
`endif

        // Reset mid-frame is silent
        base_err = err_cnt;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(TMO + 50);
        check("t7_no_err", err_cnt - base_err, 32'd0);
        check("t7_valid", 32'(ev_if.ev_valid), 32'd0);
        send_frame(8'h2B, 1'b0, 1'b1, 0);
        chk_ev("t7_rec", {2'b00, 8'h2B});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
